// File: rtl/pim_dram_scheduler.sv
// pim_dram_scheduler: open-page command scheduler sharing one DRAM bank between
// the PIM units. Round-robin arbitration, ACT/RD/WR/PRE sequencing with
// tRCD/tRAS/tWR/tRP enforced by saturating down-counters.
// Optional feature macro: PIM_SCHED_ROW_HIT_FIRST_EN (open-row hits win arbitration).
module pim_dram_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int TRCD    = 10,
    parameter int TRAS    = 22,
    parameter int TWR     = 7,
    parameter int TRP     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_row,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       cmd_valid,
    output logic [1:0]                 cmd_op,
    output logic [ADDR_W-1:0]          cmd_row,
    output logic [$clog2(NUM_REQ)-1:0] cmd_id,
    output logic                       row_open,
    output logic                       busy
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int MAX_AB = (TRCD > TRAS) ? TRCD : TRAS;
    localparam int MAX_CD = (TWR > TRP) ? TWR : TRP;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T + 1);

    localparam logic [1:0] OP_PRE = 2'b00;
    localparam logic [1:0] OP_ACT = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACT_WAIT, ACTIVE, PRE_WAIT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    tras_cnt;
    logic [CNT_W-1:0]    twr_cnt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     lat_id;
    logic [ADDR_W-1:0]   lat_row;
    logic                lat_we;
    logic [ADDR_W-1:0]   open_row;

    logic [ADDR_W-1:0]   rows [NUM_REQ];
    logic [NUM_REQ-1:0]  cand;
    logic [ID_W-1:0]     ptr_eff;
    logic [ID_W-1:0]     j;
    logic [ID_W-1:0]     win_id;
    logic                win_found;
    logic                row_hit;
    logic                hit_issue;
    logic                act_go;
    logic                acc_go;
    logic                pre_go;
    logic                arb_en;
    logic                do_latch;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Unpack the flat row bus into one row per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rows[i] = req_row[i*ADDR_W +: ADDR_W];
        end
    end

    assign row_hit   = (lat_row == open_row);
    assign hit_issue = (state == ACTIVE) && busy && row_hit;
    assign act_go    = ((state == IDLE) && busy) || ((state == PRE_WAIT) && (wait_cnt == '0));
    assign acc_go    = ((state == ACT_WAIT) && (wait_cnt == '0)) || hit_issue;
    assign pre_go    = (state == ACTIVE) && busy && !row_hit && (tras_cnt == '0) && (twr_cnt == '0);
    // A hit issuing this cycle frees the latch, so the next winner is picked in
    // the same cycle to sustain one access per cycle.
    assign arb_en    = ((state == IDLE) && !busy) || ((state == ACTIVE) && (!busy || hit_issue));
    assign do_latch  = arb_en && win_found;

    // Round-robin winner selection; the requester being (or just) acked is masked
    // because it still holds req_valid until it has seen its ack.
    always_comb begin
        cand = req_valid & ~req_ack;
        if (hit_issue) begin
            cand[lat_id] = 1'b0;
        end
`ifdef PIM_SCHED_ROW_HIT_FIRST_EN
        begin
            logic [NUM_REQ-1:0] hit_vec;
            hit_vec = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_vec[i] = cand[i] && (rows[i] == open_row) && (state == ACTIVE);
            end
            if (|hit_vec) begin
                cand = hit_vec;
            end
        end
`endif
        ptr_eff   = hit_issue ? next_id(lat_id) : rr_ptr;
        win_found = 1'b0;
        win_id    = '0;
        j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = ID_W'((int'(ptr_eff) + k) % NUM_REQ);
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_id    = j;
            end
        end
    end

    // Bank FSM, timing counters, request latch and registered command outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            tras_cnt  <= '0;
            twr_cnt   <= '0;
            rr_ptr    <= '0;
            lat_id    <= '0;
            lat_row   <= '0;
            lat_we    <= 1'b0;
            open_row  <= '0;
            req_ack   <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_PRE;
            cmd_row   <= '0;
            cmd_id    <= '0;
            row_open  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            req_ack   <= '0;
            if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            if (tras_cnt != '0) tras_cnt <= tras_cnt - 1'b1;
            if (twr_cnt  != '0) twr_cnt  <= twr_cnt  - 1'b1;

            if (act_go) begin
                cmd_valid <= 1'b1;
                cmd_op    <= OP_ACT;
                cmd_row   <= lat_row;
                cmd_id    <= lat_id;
                row_open  <= 1'b1;
                open_row  <= lat_row;
                wait_cnt  <= CNT_W'(TRCD - 1);
                tras_cnt  <= CNT_W'(TRAS - 1);
                state     <= ACT_WAIT;
            end else if (acc_go) begin
                cmd_valid       <= 1'b1;
                cmd_op          <= lat_we ? OP_WR : OP_RD;
                cmd_row         <= lat_row;
                cmd_id          <= lat_id;
                req_ack[lat_id] <= 1'b1;
                busy            <= 1'b0;
                rr_ptr          <= next_id(lat_id);
                if (lat_we) twr_cnt <= CNT_W'(TWR - 1);
                state           <= ACTIVE;
            end else if (pre_go) begin
                cmd_valid <= 1'b1;
                cmd_op    <= OP_PRE;
                cmd_row   <= '0;
                cmd_id    <= lat_id;
                row_open  <= 1'b0;
                wait_cnt  <= CNT_W'(TRP - 1);
                state     <= PRE_WAIT;
            end

            if (do_latch) begin
                lat_id  <= win_id;
                lat_row <= rows[win_id];
                lat_we  <= req_we[win_id];
                busy    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pim_dram_scheduler.sv
// tb_pim_dram_scheduler: directed scenarios plus randomized requesters checked
// against a timestamp-level model of the scheduling rules.
module tb_pim_dram_scheduler;
    localparam int NR   = 4;
    localparam int AW   = 10;
    localparam int TRCD = 10;
    localparam int TRAS = 22;
    localparam int TWR  = 7;
    localparam int TRP  = 10;
    localparam int SZ   = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_row;
    logic [NR-1:0]   req_ack;
    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_row;
    logic [1:0]      cmd_id;
    logic            row_open;
    logic            busy;

    pim_dram_scheduler #(
        .NUM_REQ(NR), .ADDR_W(AW), .TRCD(TRCD), .TRAS(TRAS), .TWR(TWR), .TRP(TRP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_row(req_row),
        .req_ack(req_ack),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_id(cmd_id),
        .row_open(row_open), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [1:0]    op;
        logic [AW-1:0] row;
        logic [1:0]    id;
    } cmd_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cmd_t          exp_cmd [SZ];
    logic [NR-1:0] exp_ack [SZ];
    bit busy_set [SZ];
    bit busy_clr [SZ];
    bit open_set [SZ];
    bit open_clr [SZ];
    bit e_busy, e_open;

    bit m_open;
    int m_row, m_ptr, t_act, t_wr, arb_at, ack_cyc, ack_id;

    bit vld [NR];
    bit we  [NR];
    int row [NR];
    int gap [NR];
    bit rand_en = 1'b0;

    int last_ack [NR];
    int n_ack    [NR];
    int n_act, n_pre, first_act, last_pre, last_act;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = vld[i];
            req_we[i]            = we[i];
            req_row[i*AW +: AW]  = AW'(row[i]);
        end
    endtask

    task automatic raise(input int i, input int r, input bit w);
        vld[i] = 1'b1;
        row[i] = r;
        we[i]  = w;
        drive();
    endtask

    task automatic put(input int t, input logic [1:0] op, input int r, input int id);
        if (t < SZ) begin
            exp_cmd[t].v   = 1'b1;
            exp_cmd[t].op  = op;
            exp_cmd[t].row = AW'(r);
            exp_cmd[t].id  = 2'(id);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < SZ; t++) begin
            exp_cmd[t]  = '0;
            exp_ack[t]  = '0;
            busy_set[t] = 1'b0;
            busy_clr[t] = 1'b0;
            open_set[t] = 1'b0;
            open_clr[t] = 1'b0;
        end
        e_busy = 1'b0; e_open = 1'b0;
        m_open = 1'b0; m_row = 0; m_ptr = 0;
        t_act = -1000; t_wr = -1000; arb_at = 0; ack_cyc = -1; ack_id = 0;
        for (int i = 0; i < NR; i++) begin
            last_ack[i] = -1;
            n_ack[i]    = 0;
        end
        n_act = 0; n_pre = 0; first_act = -1; last_pre = -1; last_act = -1;
    endtask

    // Arbitration decision at edge c, scheduling the whole command timeline of the winner.
    task automatic model_edge(input int c);
        bit cand [NR];
        bit any_hit;
        int w, r, ta, tp, acc, nxt, k2;
        if (c < arb_at) return;
        for (int i = 0; i < NR; i++) cand[i] = vld[i] && !(c == ack_cyc && i == ack_id);
        any_hit = 1'b0;
`ifdef PIM_SCHED_ROW_HIT_FIRST_EN
        if (m_open) begin
            for (int i = 0; i < NR; i++) if (cand[i] && row[i] == m_row) any_hit = 1'b1;
            if (any_hit) for (int i = 0; i < NR; i++) cand[i] = cand[i] && (row[i] == m_row);
        end
`endif
        w = -1;
        for (int k = 0; k < NR; k++) begin
            k2 = (m_ptr + k) % NR;
            if (w < 0 && cand[k2]) w = k2;
        end
        if (w < 0) return;
        r = row[w];
        busy_set[c] = 1'b1;
        if (!m_open) begin
            ta = c + 1;
            put(ta, 2'd1, r, w);
            open_set[ta] = 1'b1;
            t_act = ta;
            acc = ta + TRCD;
            nxt = acc + 1;
        end else if (r == m_row) begin
            acc = c + 1;
            nxt = acc;
        end else begin
            tp = t_act + TRAS;
            if (t_wr + TWR > tp) tp = t_wr + TWR;
            if (c + 1 > tp) tp = c + 1;
            put(tp, 2'd0, 0, w);
            open_clr[tp] = 1'b1;
            ta = tp + TRP;
            put(ta, 2'd1, r, w);
            open_set[ta] = 1'b1;
            t_act = ta;
            acc = ta + TRCD;
            nxt = acc + 1;
        end
        put(acc, we[w] ? 2'd3 : 2'd2, r, w);
        if (acc < SZ) begin
            exp_ack[acc][w] = 1'b1;
            busy_clr[acc]   = 1'b1;
        end
        if (we[w]) t_wr = acc;
        m_open  = 1'b1;
        m_row   = r;
        m_ptr   = (w + 1) % NR;
        arb_at  = nxt;
        ack_cyc = acc;
        ack_id  = w;
    endtask

    task automatic compare(input int c);
        cmd_t e;
        e = exp_cmd[c];
        if (busy_clr[c]) e_busy = 1'b0;
        if (busy_set[c]) e_busy = 1'b1;
        if (open_clr[c]) e_open = 1'b0;
        if (open_set[c]) e_open = 1'b1;
        check("cmd_valid", 32'(cmd_valid), 32'(e.v));
        if (e.v) begin
            check("cmd_op",  32'(cmd_op),  32'(e.op));
            check("cmd_row", 32'(cmd_row), 32'(e.row));
            check("cmd_id",  32'(cmd_id),  32'(e.id));
        end
        check("req_ack",  32'(req_ack),  32'(exp_ack[c]));
        check("row_open", 32'(row_open), 32'(e_open));
        check("busy",     32'(busy),     32'(e_busy));
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                last_ack[i] = c;
                n_ack[i]++;
            end
        end
        if (cmd_valid && cmd_op == 2'd0) begin
            n_pre++;
            last_pre = c;
        end
        if (cmd_valid && cmd_op == 2'd1) begin
            n_act++;
            last_act = c;
            if (first_act < 0) first_act = c;
        end
    endtask

    task automatic update_requesters(input int c);
        int sel;
        for (int i = 0; i < NR; i++) begin
            if (exp_ack[c][i]) begin
                vld[i] = 1'b0;
                gap[i] = int'($urandom_range(0, 3));
            end else if (rand_en && !vld[i]) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    we[i]  = ($urandom_range(0, 1) == 1);
                    sel    = int'($urandom_range(0, 3));
                    row[i] = (sel == 3) ? int'($urandom_range(0, 1023)) : ((sel == 1) ? 6 : 5);
                end
            end
        end
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(cyc);
        #1;
        compare(cyc);
        update_requesters(cyc);
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            vld[i] = 1'b0; we[i] = 1'b0; row[i] = 0; gap[i] = 0;
        end
        drive();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_op",    32'(cmd_op),    32'd0);
        check("rst_cmd_row",   32'(cmd_row),   32'd0);
        check("rst_req_ack",   32'(req_ack),   32'd0);
        check("rst_row_open",  32'(row_open),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_we = '0; req_row = '0;

        // First access from IDLE, then a hit from another requester
        do_reset();
        raise(0, 5, 1'b0);
        run_until(12);
        raise(1, 5, 1'b0);
        run_until(25);
        check("s1_first_act", 32'(first_act), 32'd1);
        check("s1_ack0",      32'(last_ack[0]), 32'd11);
        check("s1_ack1",      32'(last_ack[1]), 32'd13);
        check("s1_n_act",     32'(n_act), 32'd1);
        check("s1_n_pre",     32'(n_pre), 32'd0);

        // Miss bounded by tRAS
        do_reset();
        raise(0, 5, 1'b0);
        run_until(12);
        raise(2, 7, 1'b0);
        run_until(50);
        check("s2_pre",  32'(last_pre), 32'd23);
        check("s2_act",  32'(last_act), 32'd33);
        check("s2_ack2", 32'(last_ack[2]), 32'd43);

        // Miss bounded by tWR after a write at cycle 20
        do_reset();
        raise(0, 5, 1'b0);
        run_until(19);
        raise(1, 5, 1'b1);
        run_until(20);
        raise(2, 7, 1'b0);
        run_until(50);
        check("s3_wr_ack1", 32'(last_ack[1]), 32'd20);
        check("s3_pre",     32'(last_pre), 32'd27);
        check("s3_ack2",    32'(last_ack[2]), 32'd47);

        // Four simultaneous hits, then wrap back to requester 0
        do_reset();
        raise(3, 5, 1'b0);
        run_until(13);
        for (int i = 0; i < NR; i++) raise(i, 5, 1'b0);
        run_until(16);
        raise(0, 5, 1'b0);
        run_until(25);
        check("s4_ack1",   32'(last_ack[1]), 32'd15);
        check("s4_ack2",   32'(last_ack[2]), 32'd16);
        check("s4_ack3",   32'(last_ack[3]), 32'd17);
        check("s4_ack0",   32'(last_ack[0]), 32'd18);
        check("s4_n_ack0", 32'(n_ack[0]), 32'd2);
        check("s4_n_pre",  32'(n_pre), 32'd0);

        // Asynchronous reset during ACT_WAIT
        do_reset();
        raise(0, 5, 1'b0);
        run_until(6);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("arst_req_ack",   32'(req_ack),   32'd0);
        check("arst_row_open",  32'(row_open),  32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_cmd_id",    32'(cmd_id),    32'd0);
        do_reset();
        raise(1, 8, 1'b0);
        run_until(14);
        check("s5_first_act", 32'(first_act), 32'd1);
        check("s5_ack1",      32'(last_ack[1]), 32'd11);
        check("s5_n_ack0",    32'(n_ack[0]), 32'd0);

        // Hit versus miss competing with rr_ptr at 0
        do_reset();
        raise(3, 5, 1'b0);
        run_until(12);
        raise(0, 9, 1'b0);
        raise(2, 5, 1'b0);
        run_until(80);
`ifdef PIM_SCHED_ROW_HIT_FIRST_EN
        check("s6_ack2", 32'(last_ack[2]), 32'd13);
        check("s6_ack0", 32'(last_ack[0]), 32'd43);
`else
        check("s6_ack0", 32'(last_ack[0]), 32'd43);
        check("s6_ack2", 32'(last_ack[2]), 32'd75);
`endif

        // Randomized traffic against the model
        do_reset();
        rand_en = 1'b1;
        run_until(3000);
        rand_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pim_dram_scheduler.md
# pim_dram_scheduler

Open-page command scheduler that shares one DRAM bank between the PIM units of the matrix-multiply array. It arbitrates row-access requests round-robin and sequences ACT/RD/WR/PRE commands to the bank model. It enforces tRCD, tRAS, tWR and precharge spacing in clock cycles. It sits between the PIM unit request ports and the DRAM bank emulation; data moves on a separate path.

## Interface
- NUM_REQ, 4: requester count (one per PIM unit)
- ADDR_W, 10: row address width
- TRCD, 10: cycles from ACT to first RD/WR
- TRAS, 22: minimum cycles from ACT to PRE
- TWR, 7: minimum cycles from last WR to PRE
- TRP, 10: minimum cycles from PRE to next ACT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_row  in  NUM_REQ*ADDR_W  row per requester; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_ack  out  NUM_REQ  one-cycle pulse when that requester's RD/WR issues
- cmd_valid  out  1  command present this cycle
- cmd_op  out  2  00 PRE, 01 ACT, 10 RD, 11 WR
- cmd_row  out  ADDR_W  row for ACT/RD/WR; 0 on PRE
- cmd_id  out  $clog2(NUM_REQ)  requester that owns the command
- row_open  out  1  bank has an open row
- busy  out  1  a latched request is in flight

## Operation
- FSM states:
  - IDLE: no open row.
  - ACT_WAIT: tRCD countdown.
  - ACTIVE: row open.
  - PRE_WAIT: tRP countdown.
- Arbitration runs in IDLE, and in ACTIVE when no request is latched:
  - Round-robin winner starts from rr_ptr.
  - Winner's id, row and we are latched; busy is set.
  - rr_ptr becomes winner+1 mod NUM_REQ at ack.
- The latched request is committed. No re-arbitration until its ack. Later changes to req_valid or req_row for that requester are ignored until then.
- Requesters hold req_valid until they see req_ack. req_valid high in the cycle after an ack is a new request.
- IDLE with a latched request: issue ACT with the latched row, enter ACT_WAIT, load the tRCD counter.
- ACT_WAIT expiry: issue RD or WR, pulse req_ack[id] in the same cycle, enter ACTIVE, clear busy.
- ACTIVE, latched row equals the open row (hit): issue RD/WR next cycle with ack.
- ACTIVE, miss: issue PRE in the first cycle where both hold:
  - tRAS counter has expired (ACT+TRAS).
  - tWR counter has expired (last WR+TWR).
  - Then enter PRE_WAIT; row_open drops in the PRE cycle.
- PRE_WAIT expiry (PRE+TRP): issue ACT for the latched row.
- Open-page policy: a row stays open indefinitely with no requests.
- Timing counters are saturating down-counters sized for the largest parameter. A write reloads the tWR counter.
- No command issues while a countdown is running; cmd_valid=0 in those cycles.

## Timing
- Reset: all outputs 0, state IDLE, rr_ptr=0, no open row, counters 0. Reset asserted mid-operation aborts immediately: no ack for the latched request, and the bank model is reset with it.
- Request sampled at edge t in IDLE: ACT in cycle t+1, RD/WR and ack in cycle t+1+TRCD.
- Hit in ACTIVE, sampled at edge t: RD/WR and ack in cycle t+1. Sustained hits give one access per cycle.
- Miss: PRE at max(ACT+TRAS, lastWR+TWR, t+1). ACT at PRE+TRP. RD/WR at ACT+TRCD.
- Simultaneous requests: exactly one is latched per arbitration. The others wait without loss.
- rr_ptr wraps from NUM_REQ-1 to 0.
- At most one command per cycle. cmd_* outputs are registered.

## Configuration
- PIM_SCHED_ROW_HIT_FIRST_EN:
  - Defined: in ACTIVE, valid requests whose row equals the open row take priority, round-robin among themselves. Misses are arbitrated only when no hit is pending.
  - Undefined: pure round-robin regardless of row. Behaviour in IDLE is identical either way.

## Test plan
- Reset release, then req_valid[0]=1 read row 5 sampled at edge 0: ACT row 5 in cycle 1, RD row 5 with req_ack[0] in cycle 11, row_open=1 from cycle 1.
- Following that, req 1 read row 5 sampled at edge 12: RD at cycle 13, cmd_id=1, no PRE/ACT.
- After ACT@1 / RD@11, req 2 row 7 sampled at edge 12: PRE at cycle 23, ACT row 7 at 33, RD at 43, req_ack[2] at 43.
- WR at cycle 20 on a row opened at 1, then a miss: PRE at cycle 27 (TWR bound), not 23.
- All four req_valid on row 5, with row 5 open and rr_ptr=0: acks in order 0,1,2,3 on consecutive cycles; a re-asserted req 0 is served next (wrap).
- Async rst pulse during ACT_WAIT: all outputs 0 within the reset cycle, no ack. A new request after release restarts with ACT.
- With the macro defined, row 5 open, rr_ptr=0, req 0 on row 9 and req 2 on row 5: req 2 acked first via RD, then PRE/ACT for row 9. Without the macro, req 0 is served first.
